uart_rx_bit_timer: RTL and testbench

//  Oversampling bit timer for the UART RX path, successor to the fixed x8 edge counter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_edge_div.sv | 47 ++++
 rtl/uart_rx_bit_timer.sv | 112 +++++++++++
 tb/tb_uart_rx_bit_timer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, modes and config check for the UART RX bit timer
package uart_pkg;

    localparam int DEF_PRESCALE   = 8;
    localparam int DEF_FRAME_BITS = 10;
    localparam int MIN_PRESCALE   = 4;
    localparam int MIN_FRAME_BITS = 2;
    localparam int NUM_SAMPLES    = 3;

    // Per-cycle operating mode, derived from enable, run state and config error
    typedef enum logic [1:0] {
        TM_IDLE  = 2'd0,
        TM_LOAD  = 2'd1,
        TM_COUNT = 2'd2,
        TM_HOLD  = 2'd3
    } timer_mode_e;

    function automatic logic prescale_legal(input int unsigned p);
        return (p >= MIN_PRESCALE) && (p[0] == 1'b0);
    endfunction

endpackage

// File: rtl/uart_edge_div.sv
// rtl/uart_edge_div.sv - per-bit edge divider: latched prescale, edge counter, wrap and resync
module uart_edge_div
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_count,
    input  logic                  i_resync,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [PRESCALE_W-1:0] o_p_q,
    output logic                  o_wrap
);

    logic [PRESCALE_W-1:0] r_edge;
    logic [PRESCALE_W-1:0] r_p;
    logic                  w_last;

    assign w_last     = (r_edge == (r_p - PRESCALE_W'(1)));
    // A resync restarts the bit, so it suppresses the wrap that would advance bit_cnt
    assign o_wrap     = i_count && !i_resync && w_last;
    assign o_edge_cnt = r_edge;
    assign o_p_q      = r_p;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge <= '0;
            r_p    <= PRESCALE_W'(DEF_PRESCALE);
        end else if (i_clear) begin
            r_edge <= '0;
        end else if (i_load) begin
            r_p    <= i_prescale;
            r_edge <= '0;
        end else if (i_count) begin
            if (i_resync || w_last) begin
                r_edge <= '0;
            end else begin
                r_edge <= r_edge + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - oversampling UART RX bit timer with mid-bit sample strobes
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic                   resync,
    input  logic [PRESCALE_W-1:0]  prescale,
    input  logic [BIT_CNT_W-1:0]   frame_bits,
    output logic [PRESCALE_W-1:0]  edge_cnt,
    output logic [BIT_CNT_W-1:0]   bit_cnt,
    output logic [NUM_SAMPLES-1:0] sample_stb,
    output logic                   bit_done,
    output logic                   frame_done,
    output logic                   cfg_err
);

    logic                  r_run;
    logic [BIT_CNT_W-1:0]  r_f;
    timer_mode_e           w_mode;
    logic                  w_cfg_bad;
    logic                  w_wrap;
    logic                  w_active;
    logic [PRESCALE_W-1:0] w_p;
    logic [PRESCALE_W-1:0] w_mid;

    always_comb begin
        w_mode = TM_IDLE;
        if (!enable) begin
            w_mode = TM_IDLE;
        end else if (!r_run) begin
            w_mode = TM_LOAD;
        end else if (cfg_err) begin
            w_mode = TM_HOLD;
        end else begin
            w_mode = TM_COUNT;
        end
    end

    assign w_cfg_bad = !prescale_legal(32'(prescale)) ||
                       (frame_bits < BIT_CNT_W'(MIN_FRAME_BITS));

    uart_edge_div #(
        .PRESCALE_W (PRESCALE_W)
    ) u_edge_div (
        .CLK        (CLK),
        .RST        (RST),
        .i_clear    (w_mode == TM_IDLE),
        .i_load     (w_mode == TM_LOAD),
        .i_count    (w_mode == TM_COUNT),
        .i_resync   (resync),
        .i_prescale (prescale),
        .o_edge_cnt (edge_cnt),
        .o_p_q      (w_p),
        .o_wrap     (w_wrap)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_run   <= 1'b0;
            r_f     <= BIT_CNT_W'(DEF_FRAME_BITS);
            bit_cnt <= '0;
            cfg_err <= 1'b0;
        end else begin
            case (w_mode)
                TM_IDLE: begin
                    r_run   <= 1'b0;
                    bit_cnt <= '0;
                    cfg_err <= 1'b0;
                end
                TM_LOAD: begin
                    r_run   <= 1'b1;
                    r_f     <= frame_bits;
                    cfg_err <= w_cfg_bad;
                    bit_cnt <= '0;
                end
                TM_COUNT: begin
                    if (w_wrap) begin
                        if (bit_cnt == (r_f - BIT_CNT_W'(1))) begin
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                TM_HOLD: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Strobes decode the registered counters directly, so they carry no extra latency
    assign w_active = r_run && !cfg_err;
    assign w_mid    = w_p >> 1;

    always_comb begin
        sample_stb = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            sample_stb[i] = w_active &&
                (edge_cnt == (w_mid - PRESCALE_W'(1) + PRESCALE_W'(i)));
        end
    end

    assign bit_done   = w_active && (edge_cnt == (w_p - PRESCALE_W'(1)));
    assign frame_done = bit_done && (bit_cnt == (r_f - BIT_CNT_W'(1)));

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb/tb_uart_rx_bit_timer.sv - scoreboard testbench for uart_rx_bit_timer
module tb_uart_rx_bit_timer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       enable;
    logic       resync;
    logic [5:0] prescale;
    logic [3:0] frame_bits;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [2:0] sample_stb;
    logic       bit_done;
    logic       frame_done;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];

    uart_rx_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (enable),
        .resync     (resync),
        .prescale   (prescale),
        .frame_bits (frame_bits),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .sample_stb (sample_stb),
        .bit_done   (bit_done),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Ideal timing of events: every cycle with a strobe or bit_done, from edge 0 of bit b0
    task automatic push_span(input int p, input int f, input int b0, input int n);
        int e, b, m;
        logic [2:0] stb;
        logic bd, fd;
        for (int k = 0; k < n; k++) begin
            e   = k % p;
            b   = (b0 + k / p) % f;
            m   = p / 2;
            stb = {e == m + 1, e == m, e == m - 1};
            bd  = (e == p - 1);
            fd  = bd && (b == f - 1);
            if (stb != 3'b000 || bd) exp_q.push_back({6'(e), 4'(b), stb, bd, fd});
        end
    endtask

    always @(negedge CLK) begin
        if (sample_stb != 3'b000 || bit_done || frame_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {17'd0, edge_cnt, bit_cnt, sample_stb, bit_done, frame_done}, 32'h7fff_ffff);
            end else begin
                chk("event", {17'd0, edge_cnt, bit_cnt, sample_stb, bit_done, frame_done}, {17'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk(name, {17'd0, edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, cfg_err}, 32'd0);
    endtask

    task automatic start(input int p, input int f);
        prescale   = 6'(p);
        frame_bits = 4'(f);
        enable     = 1'b1;
        cyc(1);
        chk("start_state", {28'd0, cfg_err, edge_cnt == 0, bit_cnt == 0, 1'b0}, 32'b0110);
    endtask

    task automatic stop(input string name);
        enable = 1'b0;
        cyc(1);
        chk_idle(name);
        chk("drain", exp_q.size(), 0);
        cyc(1);
    endtask

    initial begin
        RST        = 1'b0;
        enable     = 1'b0;
        resync     = 1'b0;
        prescale   = 6'd8;
        frame_bits = 4'd10;
        #1;
        chk_idle("reset_state");
        cyc(2);
        RST = 1'b1;
        cyc(1);
        chk_idle("idle_after_reset");

        // P=8 F=10: one full frame, then wrap to bit 0 edge 0
        start(8, 10);
        push_span(8, 10, 0, 80);
        cyc(80);
        chk("t1_wrap_edge", edge_cnt, 0);
        chk("t1_wrap_bit", bit_cnt, 0);
        stop("t1_stop");

        // P=16 F=11, mid-frame prescale change is ignored
        start(16, 11);
        push_span(16, 11, 0, 176);
        cyc(48);
        prescale = 6'd8;
        cyc(128);
        chk("t2_wrap_edge", edge_cnt, 0);
        chk("t2_wrap_bit", bit_cnt, 0);
        stop("t2_stop");

        // Drop enable at bit 4 edge 5, then restart at P=32
        start(8, 10);
        push_span(8, 10, 0, 38);
        cyc(37);
        chk("t3_pos", {edge_cnt, bit_cnt}, {6'd5, 4'd4});
        stop("t3_drop");
        start(32, 3);
        push_span(32, 3, 0, 96);
        cyc(96);
        chk("t3_p32_wrap", {edge_cnt, bit_cnt}, 10'd0);
        stop("t3_p32_stop");

        // Illegal configurations latch cfg_err and hold counters
        for (int i = 0; i < 3; i++) begin
            prescale   = (i == 0) ? 6'd5 : (i == 1) ? 6'd2 : 6'd8;
            frame_bits = (i == 2) ? 4'd1 : 4'd10;
            enable     = 1'b1;
            cyc(1);
            chk("t4_cfg_err", cfg_err, 1);
            cyc(10);
            chk("t4_held", {cfg_err, edge_cnt, bit_cnt}, {1'b1, 10'd0});
            stop("t4_clear");
        end

        // Resync on the last edge of bit 2: no bit increment, next bit_done 8 cycles on
        start(8, 10);
        push_span(8, 10, 0, 24);
        cyc(23);
        resync = 1'b1;
        cyc(1);
        resync = 1'b0;
        chk("t5_resync", {edge_cnt, bit_cnt}, {6'd0, 4'd2});
        push_span(8, 10, 2, 16);
        cyc(15);
        chk("t5_after", {edge_cnt, bit_cnt}, {6'd7, 4'd3});
        stop("t5_stop");

        // Async reset mid-frame, then a fresh rise with P=4 F=2
        start(8, 10);
        push_span(8, 10, 0, 19);
        cyc(19);
        RST = 1'b0;
        #1;
        chk_idle("t6_async_reset");
        enable = 1'b0;
        cyc(2);
        RST = 1'b1;
        cyc(5);
        chk_idle("t6_idle");
        chk("t6_drain", exp_q.size(), 0);
        start(4, 2);
        push_span(4, 2, 0, 8);
        cyc(8);
        chk("t6_p4_wrap", {edge_cnt, bit_cnt}, 10'd0);
        stop("t6_stop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
